// File: rtl/mp_addsub_pkg.sv
// Shared encodings and sizing helpers for the multi-precision add/sub sequencer.
package mp_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of the word index; kept at least one bit wide.
    function automatic int k_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// W-bit carry-lookahead add/sub slice with an independent carry-in so slices chain in time.
module addsub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         inv,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         cmsb
);

    logic [W-1:0] bx;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   c;

    assign bx = b ^ {W{inv}};
    assign p  = a ^ bx;
    assign g  = a & bx;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, each carry formed independently.
    always_comb begin
        logic acc;
        logic run_p;
        acc   = 1'b0;
        run_p = 1'b0;
        c     = '0;
        c[0]  = cin;
        for (int i = 0; i < W; i++) begin
            acc   = g[i];
            run_p = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (run_p & g[j]);
                run_p = run_p & p[j];
            end
            c[i+1] = acc | (run_p & cin);
        end
    end

    assign s    = p ^ c[W-1:0];
    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/mp_addsub_seq.sv
// Sequential N*W-bit add/subtract: one W-bit slice per cycle, LSW first, carry chained in a register.
module mp_addsub_seq
    import mp_addsub_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           mode,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] result,
    output logic           carry,
    output logic           ovf
);

    localparam int            KW     = k_width(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Handshake: start is a request taken only in IDLE or DONE (operands captured on that
    // edge); busy marks the N processing cycles; done pulses one cycle with results valid.
    state_t         state, state_nxt;
    logic           accept;
    logic [KW-1:0]  k;
    logic [N*W-1:0] a_q, b_q;
    logic           mode_q;
    logic           cy_q;

    logic [W-1:0]   s_word;
    logic           s_cout;
    logic           s_cmsb;

    addsub_slice #(.W(W)) u_slice (
        .a    (a_q[int'(k)*W +: W]),
        .b    (b_q[int'(k)*W +: W]),
        .inv  (mode_q),
        .cin  (cy_q),
        .s    (s_word),
        .cout (s_cout),
        .cmsb (s_cmsb)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (k == K_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                accept    = start;
                state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            cy_q   <= 1'b0;
            result <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            // Subtract is invert-plus-one, so the initial carry equals the mode bit.
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            cy_q   <= mode;
            k      <= '0;
        end else if (state == ST_RUN) begin
            result[int'(k)*W +: W] <= s_word;
            cy_q                   <= s_cout;
            if (k == K_LAST) begin
                k     <= '0;
                carry <= s_cout;
                ovf   <= s_cout ^ s_cmsb;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Directed + random bench for mp_addsub_seq (W=4, N=4) with an expected-result queue.
module tb_mp_addsub_seq;
    import mp_addsub_pkg::*;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int OW = W * N;
    localparam int EW = OW + 2;

    // clock/reset and DUT
    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [OW-1:0] a;
    logic [OW-1:0] b;
    logic          busy;
    logic          done;
    logic [OW-1:0] result;
    logic          carry;
    logic          ovf;

    always #5 clk = ~clk;

    mp_addsub_seq #(.W(W), .N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .carry  (carry),
        .ovf    (ovf)
    );

    int            tests = 0;
    int            fails = 0;
    bit            overlap = 1'b0;
    logic [EW-1:0] exp_q[$];

    always @(negedge clk) if (busy && done) overlap = 1'b1;

    // scoreboard entry = {result, carry, ovf}
    function automatic logic [EW-1:0] model(input logic [OW-1:0] x, input logic [OW-1:0] y,
                                            input logic m);
        logic [OW-1:0] yx;
        logic [OW:0]   full;
        logic          v;
        yx   = m ? ~y : y;
        full = {1'b0, x} + {1'b0, yx} + (OW + 1)'(m);
        v    = (x[OW-1] == yx[OW-1]) && (full[OW-1] != x[OW-1]);
        return {full[OW-1:0], full[OW], v};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        assert (got === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // driver: raise start with operands at a negedge and queue the expected result
    task automatic drive_start(input logic [OW-1:0] x, input logic [OW-1:0] y, input logic m,
                               input logic [EW-1:0] expv);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        mode  = m;
        exp_q.push_back(expv);
    endtask

    task automatic compare_result(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e[EW-1:2]));
            check({tag, "_carry"},  32'(carry),  32'(e[1]));
            check({tag, "_ovf"},    32'(ovf),    32'(e[0]));
        end
    endtask

    task automatic wait_done(input string tag, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) busy_n++;
            if (done) break;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (done) compare_result(tag);
    endtask

    initial begin
        int lat;
        int bn;
        logic [OW-1:0] rx, ry;
        logic          rm;

        rst_n = 1'b0;
        start = 1'b0;
        mode  = MODE_ADD;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry",  32'(carry),  32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        rst_n = 1'b1;

        drive_start(16'h1234, 16'h0FCD, MODE_ADD, {16'h2201, 1'b0, 1'b0});
        wait_done("add1", lat, bn);
        check("add1_latency", 32'(lat), 32'd5);
        check("add1_busy_cycles", 32'(bn), 32'd4);
        @(negedge clk);
        check("add1_done_pulse", 32'(done), 32'd0);

        drive_start(16'h7FFF, 16'h0001, MODE_ADD, {16'h8000, 1'b0, 1'b1});
        wait_done("add_ovf", lat, bn);
        drive_start(16'hFFFF, 16'h0001, MODE_ADD, {16'h0000, 1'b1, 1'b0});
        wait_done("add_wrap", lat, bn);
        drive_start(16'h0000, 16'h0001, MODE_SUB, {16'hFFFF, 1'b0, 1'b0});
        wait_done("sub_borrow", lat, bn);
        drive_start(16'h8000, 16'h0001, MODE_SUB, {16'h7FFF, 1'b1, 1'b1});
        wait_done("sub_ovf", lat, bn);

        // start held high through RUN with operands scrambled every cycle
        drive_start(16'h1234, 16'h0FCD, MODE_ADD, {16'h2201, 1'b0, 1'b0});
        lat = 0;
        bn  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bn++;
            if (done) break;
            a    = 16'($urandom_range(0, 65535));
            b    = 16'($urandom_range(0, 65535));
            mode = 1'($urandom_range(0, 1));
        end
        check("hold_done", 32'(done), 32'd1);
        check("hold_latency", 32'(lat), 32'd5);
        check("hold_busy_cycles", 32'(bn), 32'd4);
        if (done) compare_result("hold");
        // back-to-back start accepted in the done cycle
        a    = 16'h0005;
        b    = 16'h0003;
        mode = MODE_ADD;
        exp_q.push_back({16'h0008, 1'b0, 1'b0});
        wait_done("b2b", lat, bn);
        check("b2b_latency", 32'(lat), 32'd5);

        for (int i = 0; i < 6; i++) begin
            rx = 16'($urandom_range(0, 65535));
            ry = 16'($urandom_range(0, 65535));
            rm = 1'($urandom_range(0, 1));
            drive_start(rx, ry, rm, model(rx, ry, rm));
            wait_done("rand", lat, bn);
        end

        // reset during the second RUN cycle
        drive_start(16'h1234, 16'h1111, MODE_ADD, model(16'h1234, 16'h1111, MODE_ADD));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carry",  32'(carry),  32'd0);
        check("abort_ovf",    32'(ovf),    32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        drive_start(16'h00FF, 16'h0001, MODE_ADD, {16'h0100, 1'b0, 1'b0});
        wait_done("post_reset", lat, bn);
        check("post_reset_latency", 32'(lat), 32'd5);

        check("busy_done_overlap", 32'(overlap), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
